generic_dpram: RTL and testbench



---
 rtl/generic_dpram.sv | 49 ++++
 tb/tb_generic_dpram.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/generic_dpram.sv
// Single-clock dual-port RAM: one write port, one read port with a registered
// read address and combinational (write-through) read data. Read data port is do_o since do is reserved.
module generic_dpram #(
    parameter int unsigned aw = 5,
    parameter int unsigned dw = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rce,
    input  logic          oe,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] do_o,
    input  logic          wce,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] di
);

    localparam int unsigned Depth = 2 ** aw;

    logic [dw-1:0] mem [Depth];
    logic [aw-1:0] ra_q;
    logic [aw-1:0] ra_d;

    always_ff @(posedge clk) begin
        if (wce && we) begin
            mem[waddr] <= di;
        end
    end

    always_comb begin
        ra_d = ra_q;
        if (rce) begin
            ra_d = raddr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra_q <= '0;
        end else begin
            ra_q <= ra_d;
        end
    end

    // Array read is combinational so a write to mem[ra_q] shows up right after the edge.
    assign do_o = oe ? mem[ra_q] : '0;

endmodule

// File: tb/tb_generic_dpram.sv
// Directed bench for generic_dpram (aw=8, dw=8): vector table plus reset,
// reset-release and FIFO-style streaming sequences.
module tb_generic_dpram;

    logic       clk;
    logic       rst;
    logic       rce;
    logic       oe;
    logic [7:0] raddr;
    logic [7:0] do_o;
    logic       wce;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] di;

    int unsigned n_cmp;
    int unsigned n_mis;

    generic_dpram #(.aw(8), .dw(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .rce   (rce),
        .oe    (oe),
        .raddr (raddr),
        .do_o  (do_o),
        .wce   (wce),
        .we    (we),
        .waddr (waddr),
        .di    (di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wce;
        logic       we;
        logic [7:0] waddr;
        logic [7:0] di;
        logic       rce;
        logic [7:0] raddr;
        logic       oe;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w_ce, input logic w_e, input logic [7:0] wa, input logic [7:0] d,
                         input logic r_ce, input logic [7:0] ra, input logic o_e);
        wce   = w_ce;
        we    = w_e;
        waddr = wa;
        di    = d;
        rce   = r_ce;
        raddr = ra;
        oe    = o_e;
    endtask

    function automatic logic [7:0] pat(input int unsigned i);
        return 8'((i * 7 + 3) & 8'hFF);
    endfunction

    initial begin
        logic [7:0] rp;

        n_cmp = 0;
        n_mis = 0;

        //            wce we  waddr  di     rce raddr  oe  exp
        vt[0]  = '{1, 1, 8'h10, 8'h3C, 1, 8'h00, 1, 8'hA5, "wr10_rd0"};
        vt[1]  = '{0, 0, 8'h00, 8'h00, 1, 8'h10, 1, 8'h3C, "rd10"};
        vt[2]  = '{1, 1, 8'h05, 8'h55, 1, 8'h10, 1, 8'h3C, "wr05"};
        vt[3]  = '{0, 1, 8'h05, 8'hFF, 1, 8'h05, 1, 8'h55, "wce_gate"};
        vt[4]  = '{1, 0, 8'h05, 8'hEE, 1, 8'h05, 1, 8'h55, "we_gate"};
        vt[5]  = '{0, 0, 8'h00, 8'h00, 0, 8'h10, 1, 8'h55, "rce_hold"};
        vt[6]  = '{0, 0, 8'h00, 8'h00, 1, 8'h10, 0, 8'h00, "oe_off"};
        vt[7]  = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 8'h3C, "oe_on_hold"};
        vt[8]  = '{1, 1, 8'h07, 8'h11, 1, 8'h07, 1, 8'h11, "rdw_same_cycle"};
        vt[9]  = '{1, 1, 8'h07, 8'h22, 0, 8'h00, 1, 8'h22, "rdw_write_thru"};
        vt[10] = '{1, 1, 8'hFF, 8'hC3, 1, 8'h07, 1, 8'h22, "wr_ff"};
        vt[11] = '{1, 1, 8'h00, 8'h3D, 1, 8'hFF, 1, 8'hC3, "rd_ff"};
        vt[12] = '{0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 8'h3D, "rd_00"};

        rst = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);
        repeat (2) @(posedge clk);

        // Writes proceed while reset holds ra at 0
        @(negedge clk);
        drive(1, 1, 8'h00, 8'hA5, 1, 8'h33, 1);
        @(posedge clk);
        #1;
        chk("reset_do_mem0", do_o, 8'hA5);
        @(negedge clk);
        drive(1, 1, 8'h33, 8'h5C, 0, 8'h00, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_after_release", do_o, 8'hA5);
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 1, 8'h33, 1);
        @(posedge clk);
        #1;
        chk("rd33", do_o, 8'h5C);
        // Asynchronous reset mid-cycle points ra back at 0 without a clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", do_o, 8'hA5);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 1);

        for (int unsigned i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vt[i].wce, vt[i].we, vt[i].waddr, vt[i].di, vt[i].rce, vt[i].raddr, vt[i].oe);
            @(posedge clk);
            #1;
            chk(vt[i].name, do_o, vt[i].exp);
        end

        // oe is purely combinational
        @(negedge clk);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        #1;
        chk("oe_comb_low", do_o, 8'h00);
        oe = 1'b1;
        #1;
        chk("oe_comb_high", do_o, 8'h3D);

        // Reset held across a write edge; the write lands, ra stays 0
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 8'h20, 8'h77, 1, 8'h20, 1);
        @(posedge clk);
        #1;
        chk("rst_write_ra0", do_o, 8'h3D);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 8'h00, 8'h00, 1, 8'h20, 1);
        @(posedge clk);
        #1;
        chk("rst_write_landed", do_o, 8'h77);

        // FIFO-style: write at wp=i, read at rp=i-1, then read past 8'hFF into 0
        for (int unsigned i = 0; i < 258; i++) begin
            rp = 8'(i - 1);
            @(negedge clk);
            drive(i < 256 ? 1'b1 : 1'b0, 1'b1, 8'(i), pat(i), 1'b1, rp, 1'b1);
            @(posedge clk);
            #1;
            if (i >= 1) begin
                chk("fifo_stream", do_o, pat(rp));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
